// File: rtl/pipe_ctrl_if.sv
// Pipeline-to-controller signal bundle: stage stall requests and exception
// report in, per-stage stall/flush/redirect and status out.
interface pipe_ctrl_if;
  logic        STALLREQ_IF;
  logic        STALLREQ_ID;
  logic        STALLREQ_EX;
  logic        STALLREQ_MEM;
  logic        EXCEPT_VALID;
  logic [31:0] EXCEPT_VEC;
  logic [5:0]  STALL;
  logic        FLUSH;
  logic [31:0] NEW_PC;
  logic        WDT_ERR;
  logic [31:0] STALL_CNT;

  modport master (
    output STALLREQ_IF, STALLREQ_ID, STALLREQ_EX, STALLREQ_MEM,
    output EXCEPT_VALID, EXCEPT_VEC,
    input  STALL, FLUSH, NEW_PC, WDT_ERR, STALL_CNT
  );

  modport slave (
    input  STALLREQ_IF, STALLREQ_ID, STALLREQ_EX, STALLREQ_MEM,
    input  EXCEPT_VALID, EXCEPT_VEC,
    output STALL, FLUSH, NEW_PC, WDT_ERR, STALL_CNT
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority stall decode, exception
// flush-and-redirect sequence, stall watchdog and saturating stall counter.
module pipe_ctrl #(
  parameter int unsigned WDT_LIMIT = 1023
) (
  input logic        CLK,
  input logic        RST,
  pipe_ctrl_if.slave pif
);
  // state       | meaning
  // ST_RUN      | normal flow; STALL decoded from requests; exceptions accepted
  // ST_FLUSH    | one cycle clearing every pipeline register
  // ST_REDIRECT | one cycle loading NEW_PC into PC; other stages hold the bubble

  localparam int WDT_W = ($clog2(WDT_LIMIT + 1) > 10) ? $clog2(WDT_LIMIT + 1) : 10;
  localparam logic [WDT_W-1:0] WDT_LIM = WDT_W'(WDT_LIMIT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [5:0]       stall_req;
  logic [5:0]       stall;
  logic             flush;
  logic             accept;
  logic             stall_any;
  logic             wdt_inc;
  logic [WDT_W-1:0] wdt_cnt_q;
  logic [WDT_W-1:0] wdt_cnt_d;
  logic             wdt_err_q;
  logic [31:0]      new_pc_q;
  logic [31:0]      stall_cnt_q;

  // The deepest stalled stage wins; every stage upstream of it stops too.
  always_comb begin
    stall_req = 6'b000000;
    if (pif.STALLREQ_MEM)
      stall_req = 6'b011111;
    else if (pif.STALLREQ_EX)
      stall_req = 6'b001111;
    else if (pif.STALLREQ_ID)
      stall_req = 6'b000111;
    else if (pif.STALLREQ_IF)
      stall_req = 6'b000011;
  end

  always_comb begin
    state_d = state_q;
    stall   = 6'b000000;
    flush   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = stall_req;
        if (pif.EXCEPT_VALID) begin
          accept  = 1'b1;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall   = 6'b111110;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    // Stop requests must not leak out while the controller is held in reset.
    if (!RST)
      stall = 6'b000000;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  assign stall_any = |stall;
  // An accepted exception restarts the watchdog even if it would trip now.
  assign wdt_inc   = (state_q == ST_RUN) && stall_any && !accept;

  always_comb begin
    wdt_cnt_d = '0;
    if (wdt_inc)
      wdt_cnt_d = (wdt_cnt_q == WDT_LIM) ? wdt_cnt_q : wdt_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wdt_cnt_q <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      if (wdt_inc && (wdt_cnt_d == WDT_LIM))
        wdt_err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      new_pc_q <= 32'h0;
    else if (accept)
      new_pc_q <= pif.EXCEPT_VEC;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      stall_cnt_q <= 32'h0;
    else if (stall_any && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign pif.STALL     = stall;
  assign pif.FLUSH     = flush;
  assign pif.NEW_PC    = new_pc_q;
  assign pif.WDT_ERR   = wdt_err_q;
  assign pif.STALL_CNT = stall_cnt_q;

endmodule
